mem_port_scheduler: RTL and testbench
=====================================

Name: mem_port_scheduler

Overview:
- Three-requester scheduler for the single cacheline memory port into the cacheline adaptor. Requesters are the D-cache, the I-cache and the I-side next-line prefetcher.
- Default priority is D > I > P, with a starvation guard for the I-cache.
- Grants are non-preemptive. Address, write data and command are latched at grant and held until `mem_resp`.

Parameters:
- STARVE_MAX, 4: consecutive D grants allowed while an I request is pending; the next arbitration then goes to I.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- data_mem_read  in  1  D-cache line read request
- data_mem_write  in  1  D-cache line writeback request
- data_mem_addr  in  32  D-cache line address
- data_mem_wdata  in  256  D-cache writeback data
- data_mem_rdata  out  256  read data to D-cache
- data_mem_resp  out  1  D transaction done
- inst_mem_read  in  1  I-cache line read request
- inst_mem_addr  in  32  I-cache line address
- inst_mem_rdata  out  256  read data to I-cache
- inst_mem_resp  out  1  I transaction done
- pf_mem_read  in  1  prefetcher line read request
- pf_mem_addr  in  32  prefetch line address
- pf_mem_rdata  out  256  read data to prefetcher
- pf_mem_resp  out  1  P transaction done
- mem_rdata  in  256  adaptor read data
- mem_resp  in  1  adaptor done, one-cycle pulse
- mem_read  out  1  adaptor read command
- mem_write  out  1  adaptor write command
- mem_address  out  32  adaptor line address
- mem_wdata  out  256  adaptor write data
- grant_owner  out  2  0 = none, 1 = D, 2 = I, 3 = P; performance/debug

Behaviour:
- **State machine.** States are IDLE, GNT_D, GNT_I, GNT_P. IDLE is the only state where arbitration happens. A grant state is left only on `mem_resp` and always returns to IDLE. This gives a mandatory one-cycle gap between transactions so the finished requester can drop its request.
- **Arbitration in IDLE.**
  - D pending means `data_mem_read | data_mem_write`.
  - If I is pending and `starve_cnt == STARVE_MAX`, go to GNT_I.
  - Otherwise D wins, then I, then P.
  - With no request, stay in IDLE.
- **Latching at the IDLE -> grant edge.** Register the winner's address into `mem_address`. For D only, also register `data_mem_wdata` into `mem_wdata` and register `mem_read`/`mem_write`. Commands are asserted starting the cycle after the request is first seen in IDLE (1-cycle grant latency).
- **Command hold.** `mem_read`/`mem_write` stay high through the `mem_resp` cycle. They are cleared on the edge that returns to IDLE. They are never both 1. If D asserts both read and write, write takes precedence.
- **Response routing.**
  - The owner's `*_resp` equals `mem_resp`, combinational, only while in its grant state. Every other `*_resp` is 0.
  - All three `*_rdata` outputs are driven with `mem_rdata` at all times.
- **Starvation counter (`starve_cnt`).**
  - Increments, saturating at STARVE_MAX, on each GNT_D grant taken while `inst_mem_read` = 1.
  - Clears on any GNT_I grant.
  - Clears on any arbitration in IDLE where `inst_mem_read` = 0.
- **Request drops.** A requester dropping its request mid-grant has no effect. The transaction completes and `resp` is still pulsed.
- **Reset.** Reset at any time, including mid-transaction, forces:
  - state = IDLE, `starve_cnt` = 0
  - `mem_read` = `mem_write` = 0, `mem_address` = 0, `mem_wdata` = 0
  - all `*_resp` = 0, `grant_owner` = 0
  
  The adaptor is assumed to be reset in the same cycle.
- **`grant_owner`.** Registered, and tracks the state encoding.

Optional Feature:
- Macro `MEM_SCHED_PF_MERGE_EN`.
- **Defined:** while in GNT_P, if `inst_mem_read` = 1 and `inst_mem_addr[31:5] == mem_address[31:5]`, then `inst_mem_resp` = `mem_resp` in the same cycle as `pf_mem_resp`. Both receive `mem_rdata`, so the demand miss merges into the in-flight prefetch. The merged I completion also clears `starve_cnt`.
- **Not defined:** the I request waits for IDLE and is issued as a separate memory transaction.

Test Plan:
- **Lone D write.** After reset, `data_mem_write` = 1, `addr` = 0x0000_1040, `wdata` = pattern A. Next cycle `mem_write` = 1, `mem_address` = 0x0000_1040, `mem_wdata` = A. On `mem_resp`, `data_mem_resp` = 1 for one cycle. Next cycle `mem_write` = 0 and state = IDLE.
- **Simultaneous I and D.** I `addr` = 0x200, D read `addr` = 0x400, both asserted in the same cycle. D is served first, then one idle cycle, then `mem_read` with `mem_address` = 0x200. `inst_mem_resp` is never asserted during the D transaction.
- **Starvation guard.** STARVE_MAX = 4; D re-requests every time it is free while I is held high. Exactly 4 D grants occur, then the 5th grant goes to I even though D is pending, and `starve_cnt` reads 0 afterwards.
- **Prefetch priority.** P `addr` = 0x1000 pending, and I `addr` = 0x2000 arrives while GNT_P is in progress. The P transaction completes, then I is granted. With P and I pending together in IDLE, I is granted first.
- **Merge (`MEM_SCHED_PF_MERGE_EN`).** In GNT_P with `addr` 0x1000, I requests 0x1004. `pf_mem_resp` and `inst_mem_resp` both pulse on the single `mem_resp`, and there is no second memory read. Without the macro, a second read to 0x1004 follows.
- **Reset mid-grant.** Assert `rst` during GNT_D before `mem_resp`. Next cycle all outputs are 0, state = IDLE, and no stale `data_mem_resp` appears afterwards.

Source files
------------

// File: rtl/mem_port_scheduler.sv
// mem_port_scheduler: shares one cacheline memory port between D-cache, I-cache and the
// I-side next-line prefetcher. Priority D > I > P, with a starvation guard for the I-cache.
// Grants are non-preemptive and always return through IDLE.
// Optional build macro: MEM_SCHED_PF_MERGE_EN, which merges an I-cache miss into an
// in-flight prefetch of the same line.
module mem_port_scheduler #(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned CNT_W      = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         data_mem_read,
   input  logic         data_mem_write,
   input  logic [31:0]  data_mem_addr,
   input  logic [255:0] data_mem_wdata,
   output logic [255:0] data_mem_rdata,
   output logic         data_mem_resp,
   input  logic         inst_mem_read,
   input  logic [31:0]  inst_mem_addr,
   output logic [255:0] inst_mem_rdata,
   output logic         inst_mem_resp,
   input  logic         pf_mem_read,
   input  logic [31:0]  pf_mem_addr,
   output logic [255:0] pf_mem_rdata,
   output logic         pf_mem_resp,
   input  logic [255:0] mem_rdata,
   input  logic         mem_resp,
   output logic         mem_read,
   output logic         mem_write,
   output logic [31:0]  mem_address,
   output logic [255:0] mem_wdata,
   output logic [1:0]   grant_owner
);

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned LINE_W = 256;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_D = 2'd1,
      GNT_I = 2'd2,
      GNT_P = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_starve_cnt;
   logic                r_mem_read;
   logic                r_mem_write;
   logic [ADDR_W-1:0]   r_mem_address;
   logic [LINE_W-1:0]   r_mem_wdata;

   logic                w_d_pend;
   logic                w_starved;
   logic                w_grant;
   logic [ADDR_W-1:0]   w_grant_addr;
   logic                w_merge_hit;

   assign w_d_pend  = data_mem_read | data_mem_write;
   assign w_starved = inst_mem_read && (r_starve_cnt == CNT_W'(STARVE_MAX));
   assign w_grant   = (r_state == IDLE) && (w_state_nxt != IDLE);

`ifdef MEM_SCHED_PF_MERGE_EN
   // Demand I miss on the line already being prefetched rides on that transaction.
   assign w_merge_hit = (r_state == GNT_P) && inst_mem_read &&
                        (inst_mem_addr[31:5] == r_mem_address[31:5]);
`else
   assign w_merge_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: arbitrate only in IDLE; a grant state exits only on mem_resp.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_starved)          w_state_nxt = GNT_I;
            else if (w_d_pend)      w_state_nxt = GNT_D;
            else if (inst_mem_read) w_state_nxt = GNT_I;
            else if (pf_mem_read)   w_state_nxt = GNT_P;
            else                    w_state_nxt = IDLE;
         end
         GNT_D, GNT_I, GNT_P: begin
            if (mem_resp) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Winner's address selected for latching at the grant edge.
   always_comb begin
      w_grant_addr = pf_mem_addr;
      case (w_state_nxt)
         GNT_D:   w_grant_addr = data_mem_addr;
         GNT_I:   w_grant_addr = inst_mem_addr;
         default: w_grant_addr = pf_mem_addr;
      endcase
   end

   // Command/address/data latched at grant, held until the mem_resp edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_read    <= 1'b0;
         r_mem_write   <= 1'b0;
         r_mem_address <= '0;
         r_mem_wdata   <= '0;
      end else if (w_grant) begin
         r_mem_address <= w_grant_addr;
         if (w_state_nxt == GNT_D) begin
            r_mem_wdata <= data_mem_wdata;
            r_mem_write <= data_mem_write;
            r_mem_read  <= ~data_mem_write;
         end else begin
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b1;
         end
      end else if ((r_state != IDLE) && mem_resp) begin
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
      end
   end

   // Starvation counter: counts D grants that bypassed a waiting I request.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve_cnt <= '0;
      end else if (r_state == IDLE) begin
         if (!inst_mem_read || (w_state_nxt == GNT_I)) begin
            r_starve_cnt <= '0;
         end else if ((w_state_nxt == GNT_D) && (r_starve_cnt < CNT_W'(STARVE_MAX))) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
         end
      end else if (w_merge_hit && mem_resp) begin
         r_starve_cnt <= '0;
      end
   end

   // Response routing: only the current owner sees mem_resp.
   assign data_mem_resp = (r_state == GNT_D) && mem_resp;
   assign inst_mem_resp = ((r_state == GNT_I) || w_merge_hit) && mem_resp;
   assign pf_mem_resp   = (r_state == GNT_P) && mem_resp;

   assign data_mem_rdata = mem_rdata;
   assign inst_mem_rdata = mem_rdata;
   assign pf_mem_rdata   = mem_rdata;

   assign mem_read    = r_mem_read;
   assign mem_write   = r_mem_write;
   assign mem_address = r_mem_address;
   assign mem_wdata   = r_mem_wdata;
   assign grant_owner = r_state;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// tb_mem_port_scheduler: scoreboard bench for mem_port_scheduler. A transaction-level
// arbitration model predicts each grant; a monitor checks commands and response routing.
`timescale 1ns/1ps
module tb_mem_port_scheduler;

   localparam int unsigned STARVE_MAX = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         data_mem_read, data_mem_write;
   logic [31:0]  data_mem_addr;
   logic [255:0] data_mem_wdata, data_mem_rdata;
   logic         data_mem_resp;
   logic         inst_mem_read;
   logic [31:0]  inst_mem_addr;
   logic [255:0] inst_mem_rdata;
   logic         inst_mem_resp;
   logic         pf_mem_read;
   logic [31:0]  pf_mem_addr;
   logic [255:0] pf_mem_rdata;
   logic         pf_mem_resp;
   logic [255:0] mem_rdata;
   logic         mem_resp;
   logic         mem_read, mem_write;
   logic [31:0]  mem_address;
   logic [255:0] mem_wdata;
   logic [1:0]   grant_owner;

   mem_port_scheduler #(.STARVE_MAX(STARVE_MAX), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .data_mem_read(data_mem_read), .data_mem_write(data_mem_write),
      .data_mem_addr(data_mem_addr), .data_mem_wdata(data_mem_wdata),
      .data_mem_rdata(data_mem_rdata), .data_mem_resp(data_mem_resp),
      .inst_mem_read(inst_mem_read), .inst_mem_addr(inst_mem_addr),
      .inst_mem_rdata(inst_mem_rdata), .inst_mem_resp(inst_mem_resp),
      .pf_mem_read(pf_mem_read), .pf_mem_addr(pf_mem_addr),
      .pf_mem_rdata(pf_mem_rdata), .pf_mem_resp(pf_mem_resp),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .grant_owner(grant_owner)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned  owner;   // 1 = D, 2 = I, 3 = P
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] wdata;
   } txn_t;

   txn_t        exp_q[$];
   int unsigned n_vec    = 0;
   int unsigned n_err    = 0;
   int unsigned n_forced = 0;
   int unsigned n_grants = 0;

   int unsigned ad_lat  = 0;
   bit          ad_busy = 1'b0;
   bit          ad_hold = 1'b0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus: retire answered requests and run the memory adaptor model.
   task automatic step();
      logic dr, ir, pr;
      @(negedge clk);
      dr = data_mem_resp;
      ir = inst_mem_resp;
      pr = pf_mem_resp;
      @(posedge clk);
      #1;
      if (dr) begin data_mem_read = 1'b0; data_mem_write = 1'b0; end
      if (ir) inst_mem_read = 1'b0;
      if (pr) pf_mem_read = 1'b0;
      mem_rdata = {8{$urandom()}};
      if (rst) begin
         mem_resp = 1'b0;
         ad_busy  = 1'b0;
      end else if (mem_resp) begin
         mem_resp = 1'b0;
      end else if (ad_busy) begin
         ad_lat--;
         if (ad_lat == 0) begin mem_resp = 1'b1; ad_busy = 1'b0; end
      end else if ((mem_read || mem_write) && !ad_hold) begin
         ad_lat = $urandom_range(0, 3);
         if (ad_lat == 0) mem_resp = 1'b1;
         else             ad_busy  = 1'b1;
      end
   endtask

   task automatic run_until_idle(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 400; i++) begin
         step();
         if (!(data_mem_read || data_mem_write || inst_mem_read || pf_mem_read ||
               mem_read || mem_write || mem_resp)) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         n_vec++; n_err++;
         $display("FAIL %s: timeout waiting for idle", name);
      end
   endtask

   task automatic wait_owner(input string name, input logic [1:0] owner);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (grant_owner == owner) begin seen = 1'b1; break; end
      end
      if (!seen) begin
         n_vec++; n_err++;
         $display("FAIL %s: grant to %0d never seen", name, owner);
      end
   endtask

   task automatic new_d(input logic [31:0] a, input int kind);
      data_mem_addr  = a;
      data_mem_wdata = {8{$urandom()}};
      data_mem_read  = (kind != 1);
      data_mem_write = (kind != 0);
   endtask

   // Transaction-level reference: who wins each arbitration and what must be issued.
   initial begin : model
      int unsigned sc;
      bit          busy;
      int unsigned own;
      logic [31:0] cur_addr;
      bit          dp, ip, pp;
      txn_t        t;
      sc = 0; busy = 1'b0; own = 0; cur_addr = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            sc = 0; busy = 1'b0; own = 0;
            exp_q.delete();
         end else if (!busy) begin
            dp = data_mem_read || data_mem_write;
            ip = inst_mem_read;
            pp = pf_mem_read;
            if (!ip) sc = 0;
            own = 0;
            if (ip && sc == STARVE_MAX) begin
               own = 2;
               if (dp) n_forced++;
            end else if (dp) own = 1;
            else if (ip)     own = 2;
            else if (pp)     own = 3;
            if (own == 1 && ip && sc < STARVE_MAX) sc = sc + 1;
            if (own == 2) sc = 0;
            if (own != 0) begin
               t.owner = own;
               t.wr    = (own == 1) ? data_mem_write : 1'b0;
               t.addr  = (own == 1) ? data_mem_addr : (own == 2) ? inst_mem_addr : pf_mem_addr;
               t.wdata = data_mem_wdata;
               cur_addr = t.addr;
               exp_q.push_back(t);
               busy = 1'b1;
               n_grants++;
            end
         end else if (mem_resp) begin
`ifdef MEM_SCHED_PF_MERGE_EN
            if (own == 3 && inst_mem_read && inst_mem_addr[31:5] == cur_addr[31:5]) sc = 0;
`endif
            busy = 1'b0;
         end
      end
   end

   // Monitor: pops an expected grant when a command appears, checks routing on mem_resp.
   initial begin : monitor
      txn_t       cur;
      bit         have, prev_cmd, prev_rst;
      logic [2:0] exp_r;
      have = 1'b0; prev_cmd = 1'b0; prev_rst = 1'b0;
      cur = '{owner: 0, wr: 1'b0, addr: '0, wdata: '0};
      forever begin
         @(negedge clk);
         if (prev_rst) begin
            chk("reset_cmd",   {254'd0, mem_read, mem_write}, 256'd0);
            chk("reset_addr",  mem_address, 256'd0);
            chk("reset_wdata", mem_wdata, 256'd0);
            chk("reset_owner", grant_owner, 256'd0);
            chk("reset_resp",  {data_mem_resp, inst_mem_resp, pf_mem_resp}, 256'd0);
         end
         if (rst) begin
            have = 1'b0;
         end else begin
            if ((mem_read || mem_write) && !prev_cmd) begin
               if (exp_q.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL unexpected_grant: owner %0d addr %0h", grant_owner, mem_address);
                  have = 1'b0;
               end else begin
                  cur  = exp_q.pop_front();
                  have = 1'b1;
                  chk("grant_owner", grant_owner, cur.owner);
                  chk("grant_addr", mem_address, cur.addr);
                  chk("grant_cmd", {254'd0, mem_read, mem_write}, {254'd0, !cur.wr, cur.wr});
                  if (cur.owner == 1) chk("grant_wdata", mem_wdata, cur.wdata);
               end
            end
            if (mem_read && mem_write) chk("rw_exclusive", 1, 0);
            if (mem_resp && have) begin
               exp_r = 3'b000;
               exp_r[2] = (cur.owner == 1);
               exp_r[1] = (cur.owner == 2);
               exp_r[0] = (cur.owner == 3);
`ifdef MEM_SCHED_PF_MERGE_EN
               if (cur.owner == 3 && inst_mem_read && inst_mem_addr[31:5] == cur.addr[31:5])
                  exp_r[1] = 1'b1;
`endif
               chk("resp_route", {data_mem_resp, inst_mem_resp, pf_mem_resp}, exp_r);
               chk("rdata_d", data_mem_rdata, mem_rdata);
               chk("rdata_i", inst_mem_rdata, mem_rdata);
               chk("rdata_p", pf_mem_rdata, mem_rdata);
               have = 1'b0;
            end else if (data_mem_resp || inst_mem_resp || pf_mem_resp) begin
               chk("stray_resp", {data_mem_resp, inst_mem_resp, pf_mem_resp}, 0);
            end
         end
         prev_cmd = mem_read || mem_write;
         prev_rst = rst;
      end
   end

   // Stimulus: directed scenarios followed by randomized traffic.
   initial begin : stim
      rst = 1'b1;
      data_mem_read = 1'b0; data_mem_write = 1'b0; data_mem_addr = '0; data_mem_wdata = '0;
      inst_mem_read = 1'b0; inst_mem_addr = '0;
      pf_mem_read = 1'b0; pf_mem_addr = '0;
      mem_rdata = '0; mem_resp = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Lone D write.
      data_mem_addr = 32'h0000_1040; data_mem_wdata = {8{32'hA5A5_5A5A}}; data_mem_write = 1'b1;
      run_until_idle("lone_d_write");

      // Simultaneous I and D: D first, then I.
      inst_mem_addr = 32'h200; inst_mem_read = 1'b1;
      new_d(32'h400, 0);
      run_until_idle("i_and_d");

      // Starvation: D re-requests whenever free while I is held.
      inst_mem_addr = 32'h300; inst_mem_read = 1'b1;
      for (int i = 0; i < 300 && inst_mem_read; i++) begin
         if (!(data_mem_read || data_mem_write)) new_d($urandom(), 0);
         step();
      end
      run_until_idle("starvation");

      // Prefetch then I arriving mid-grant; then P and I together.
      ad_hold = 1'b1;
      pf_mem_addr = 32'h1000; pf_mem_read = 1'b1;
      wait_owner("pf_grant", 2'd3);
      inst_mem_addr = 32'h2000; inst_mem_read = 1'b1;
      ad_hold = 1'b0;
      run_until_idle("pf_then_i");
      pf_mem_addr = 32'h3000; pf_mem_read = 1'b1;
      inst_mem_addr = 32'h4000; inst_mem_read = 1'b1;
      run_until_idle("i_over_p");

      // Same-line I miss during a prefetch.
      ad_hold = 1'b1;
      pf_mem_addr = 32'h1000; pf_mem_read = 1'b1;
      wait_owner("merge_pf_grant", 2'd3);
      inst_mem_addr = 32'h1004; inst_mem_read = 1'b1;
      ad_hold = 1'b0;
      run_until_idle("merge");

      // Reset in the middle of a D grant.
      ad_hold = 1'b1;
      new_d(32'h800, 0);
      wait_owner("rst_d_grant", 2'd1);
      step();
      rst = 1'b1; data_mem_read = 1'b0; data_mem_write = 1'b0;
      mem_resp = 1'b0; ad_busy = 1'b0;
      step();
      rst = 1'b0; ad_hold = 1'b0;
      repeat (4) step();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         step();
         if (!(data_mem_read || data_mem_write) && $urandom_range(0, 99) < 80)
            new_d($urandom(), int'($urandom_range(0, 2)));
         if (!pf_mem_read && $urandom_range(0, 99) < 25) begin
            pf_mem_addr = $urandom(); pf_mem_read = 1'b1;
         end
         if (!inst_mem_read && $urandom_range(0, 99) < 30) begin
            if (pf_mem_read && $urandom_range(0, 1) == 1)
               inst_mem_addr = {pf_mem_addr[31:5], 5'($urandom())};
            else
               inst_mem_addr = $urandom();
            inst_mem_read = 1'b1;
         end
      end
      run_until_idle("drain");
      repeat (3) step();

      chk("scoreboard_empty", exp_q.size(), 0);
      chk("starve_guard_hit", (n_forced > 0), 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
